lm_sm_sequencer: RTL and testbench
==================================

# lm_sm_sequencer

Sequencer for the load-multiple (LM) and store-multiple (SM) instructions. It sits directly upstream of the register file and drives its write address, write enable and write data for LM, or its second read address for SM. It walks an 8-bit register mask from R0 to R7 and moves one register per memory beat between the register file and consecutive data-memory words starting at a base address. The multicycle controller starts it and waits for `Out_done`.

## Interface
- No parameters. The design is fixed at 8 registers, a 16-bit datapath and a 16-bit address.
- `In_clock` in 1: the single clock. All state updates on the rising edge.
- `In_reset` in 1: asynchronous, active-low reset.
- `In_start` in 1: one-cycle request. Sampled only in IDLE.
- `In_is_load` in 1: 1 = LM (memory to RF), 0 = SM (RF to memory). Latched at start.
- `In_reg_mask` in 8: bit i set means register Ri is transferred. Latched at start.
- `In_base_addr` in 16: first memory address. Latched at start.
- `In_mem_ready` in 1: memory completes the current beat this cycle.
- `In_mem_rdata` in 16: memory read data. Valid when `In_mem_ready` = 1.
- `In_RF_Read_data` in 16: register file read data (port 2), combinational from `Out_RF_Read_addr`.
- `Out_RF_Read_addr` out 3: current register index (used for SM).
- `Out_RF_Write_addr` out 3: current register index (used for LM).
- `Out_RF_Write_data` out 16: equals `In_mem_rdata`.
- `Out_RF_Write_en` out 1: register file write strobe.
- `Out_mem_addr` out 16: current memory address.
- `Out_mem_wdata` out 16: equals `In_RF_Read_data`.
- `Out_mem_read_en` out 1: memory read request.
- `Out_mem_write_en` out 1: memory write request.
- `Out_busy` out 1: high from the first cycle after an accepted start through DONE, inclusive.
- `Out_done` out 1: one-cycle completion pulse.
- `Out_count` out 4: number of registers transferred, 0–8.

## Operation
- States:
  - IDLE: `In_start` = 1 latches mode, mask and address and clears the count. If the mask is non-zero, go to ACCESS; if it is zero, go to DONE.
  - ACCESS: performs the transfers. After the beat that transfers the last remaining set bit, go to DONE.
  - DONE: lasts one cycle, then IDLE.
- Current register = lowest set bit of the remaining mask, via a priority encoder. Both RF address outputs carry this index. In IDLE and DONE they drive 0.
- In ACCESS:
  - LM: `Out_mem_read_en` = 1 and `Out_RF_Write_en` = `In_mem_ready`.
  - SM: `Out_mem_write_en` = 1 and `Out_RF_Write_en` = 0.
- Beat completion: a beat completes on the edge where `In_mem_ready` = 1. On that edge:
  - clear the current bit in the remaining mask;
  - address = address + 1, modulo 2^16, so 16'hFFFF wraps to 16'h0000;
  - count = count + 1.
- Stall: when `In_mem_ready` = 0, hold all state and keep the outputs stable.
- `In_start` is ignored outside IDLE, and input changes after the start cycle have no effect.
- Reset (asserted at any time, including mid-transfer):
  - state = IDLE; mask, address and count = 0;
  - all enables, `Out_busy` and `Out_done` = 0;
  - registers already written stay written. No partial beat completes after reset.
- `Out_count` holds its final value after DONE until the next accepted start.

## Timing
- Start accepted on edge E0. ACCESS runs from the cycle after E0.
- With `In_mem_ready` held at 1 and N set bits (N ≥ 1):
  - N ACCESS cycles, then 1 DONE cycle;
  - `Out_done` is high in cycle N+1 after E0;
  - total latency from start to done = N+1 cycles.
- Zero mask: DONE in the cycle after E0. Latency 1, no memory or RF strobes.
- Each stall cycle adds exactly one cycle.
- LM write strobe: the RF samples `Out_RF_Write_en`, address and data on the same edge that completes the beat.
- SM data path: `In_RF_Read_data` to `Out_mem_wdata` is combinational, so memory sees the data in the same cycle as the address.
- A new `In_start` is accepted no earlier than the IDLE cycle after DONE. Back-to-back operations therefore have a 1-cycle gap minimum, not counting DONE.

## Test plan
- LM, mask 8'b1010_0101, base 16'h0040, ready held at 1:
  - RF writes R0, R2, R5, R7 with the memory data from addresses 0x40, 0x41, 0x42, 0x43 respectively;
  - `Out_done` high 5 cycles after start; `Out_count` = 4.
- SM, mask 8'hFF, base 16'hFFFE:
  - memory writes to 0xFFFE, 0xFFFF, 0x0000 … 0x0005 (wrap) carrying R0–R7 in order;
  - `Out_RF_Write_en` never asserts; `Out_count` = 8.
- Zero mask, either mode:
  - `Out_done` high in the cycle after start;
  - no read, write or RF strobes; `Out_count` = 0.
- LM mask 8'b0000_0011 with `In_mem_ready` low for 2 cycles on the first beat:
  - R0 written on the 3rd ACCESS cycle, R1 on the 4th;
  - address and index stay stable during the stall; done 5 cycles after start.
- Start during ACCESS: a second `In_start` carrying a different mask is ignored, and the first operation completes unchanged.
- `In_reset` asserted low in the middle of an 8-register SM:
  - outputs go to 0 immediately, with no clock edge needed;
  - after release the block sits in IDLE, and a new start runs a complete, correct operation.

Source files
------------

// File: rtl/lm_sm_sequencer_if.sv
// Bus bundle between the LM/SM sequencer and its environment (multicycle
// controller, data memory and register file).
//   In_*  : driven by the environment, sampled by the sequencer
//   Out_* : driven by the sequencer
// modport slave  : the sequencer side
// modport master : the controller / memory / register-file side
interface lm_sm_sequencer_if;

    logic        In_start;
    logic        In_is_load;
    logic [7:0]  In_reg_mask;
    logic [15:0] In_base_addr;
    logic        In_mem_ready;
    logic [15:0] In_mem_rdata;
    logic [15:0] In_RF_Read_data;

    logic [2:0]  Out_RF_Read_addr;
    logic [2:0]  Out_RF_Write_addr;
    logic [15:0] Out_RF_Write_data;
    logic        Out_RF_Write_en;
    logic [15:0] Out_mem_addr;
    logic [15:0] Out_mem_wdata;
    logic        Out_mem_read_en;
    logic        Out_mem_write_en;
    logic        Out_busy;
    logic        Out_done;
    logic [3:0]  Out_count;

    modport slave (
        input  In_start,
        input  In_is_load,
        input  In_reg_mask,
        input  In_base_addr,
        input  In_mem_ready,
        input  In_mem_rdata,
        input  In_RF_Read_data,
        output Out_RF_Read_addr,
        output Out_RF_Write_addr,
        output Out_RF_Write_data,
        output Out_RF_Write_en,
        output Out_mem_addr,
        output Out_mem_wdata,
        output Out_mem_read_en,
        output Out_mem_write_en,
        output Out_busy,
        output Out_done,
        output Out_count
    );

    modport master (
        output In_start,
        output In_is_load,
        output In_reg_mask,
        output In_base_addr,
        output In_mem_ready,
        output In_mem_rdata,
        output In_RF_Read_data,
        input  Out_RF_Read_addr,
        input  Out_RF_Write_addr,
        input  Out_RF_Write_data,
        input  Out_RF_Write_en,
        input  Out_mem_addr,
        input  Out_mem_wdata,
        input  Out_mem_read_en,
        input  Out_mem_write_en,
        input  Out_busy,
        input  Out_done,
        input  Out_count
    );

endinterface

// File: rtl/lm_sm_sequencer.sv
// Load-multiple / store-multiple sequencer.
// Walks an 8-bit register mask from R0 to R7 and moves one register per
// memory beat between the register file and consecutive memory words
// starting at a base address.
// Ports:
//   In_clock : clock, rising edge
//   In_reset : asynchronous active-low reset
//   bus      : lm_sm_sequencer_if.slave (start/mode/mask/base, memory
//              handshake and data, register-file address/data/strobe,
//              busy/done/count status)
// Strobes, addresses and status decode from registered state only; the
// LM write strobe follows In_mem_ready and the two data paths are
// straight wires so a beat completes in the cycle memory signals ready.
module lm_sm_sequencer (
    input  logic               In_clock,
    input  logic               In_reset,
    lm_sm_sequencer_if.slave   bus
);

    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned CNT_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  is_load_q, is_load_d;
    logic [NUM_REGS-1:0]   mask_q, mask_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic [IDX_W-1:0]      cur_idx_c;
    logic [NUM_REGS-1:0]   mask_clr_c;
    logic                  start_ok_c;
    logic                  beat_done_c;

    logic [IDX_W-1:0]      rf_addr_c;
    logic                  rf_we_c;
    logic                  mem_re_c;
    logic                  mem_we_c;
    logic                  busy_c;
    logic                  done_c;

    // Priority encoder: lowest set bit of the remaining mask wins.
    always_comb begin
        cur_idx_c = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                cur_idx_c = IDX_W'(i);
            end
        end
    end

    // Remaining mask once the current register has been transferred.
    assign mask_clr_c  = mask_q & ~(NUM_REGS'(1) << cur_idx_c);
    assign start_ok_c  = (state_q == ST_IDLE) && bus.In_start;
    assign beat_done_c = (state_q == ST_ACCESS) && bus.In_mem_ready;

    // State register.
    always_ff @(posedge In_clock or negedge In_reset) begin
        if (!In_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.In_start) begin
                    state_d = (bus.In_reg_mask != '0) ? ST_ACCESS : ST_DONE;
                end
            end
            ST_ACCESS: begin
                if (bus.In_mem_ready && (mask_clr_c == '0)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: latch at start, advance on each completed beat.
    always_comb begin
        is_load_d = is_load_q;
        mask_d    = mask_q;
        addr_d    = addr_q;
        count_d   = count_q;
        if (start_ok_c) begin
            is_load_d = bus.In_is_load;
            mask_d    = bus.In_reg_mask;
            addr_d    = bus.In_base_addr;
            count_d   = '0;
        end else if (beat_done_c) begin
            mask_d    = mask_clr_c;
            addr_d    = addr_q + ADDR_W'(1);
            count_d   = count_q + CNT_W'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge In_clock or negedge In_reset) begin
        if (!In_reset) begin
            is_load_q <= 1'b0;
            mask_q    <= '0;
            addr_q    <= '0;
            count_q   <= '0;
        end else begin
            is_load_q <= is_load_d;
            mask_q    <= mask_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
        end
    end

    // Output decode from the current state.
    always_comb begin
        rf_addr_c = '0;
        rf_we_c   = 1'b0;
        mem_re_c  = 1'b0;
        mem_we_c  = 1'b0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        unique case (state_q)
            ST_ACCESS: begin
                busy_c    = 1'b1;
                rf_addr_c = cur_idx_c;
                mem_re_c  = is_load_q;
                mem_we_c  = !is_load_q;
                rf_we_c   = is_load_q && bus.In_mem_ready;
            end
            ST_DONE: begin
                busy_c    = 1'b1;
                done_c    = 1'b1;
            end
            default: begin
                busy_c    = 1'b0;
            end
        endcase
    end

    assign bus.Out_RF_Read_addr  = rf_addr_c;
    assign bus.Out_RF_Write_addr = rf_addr_c;
    assign bus.Out_RF_Write_data = DATA_W'(bus.In_mem_rdata);
    assign bus.Out_RF_Write_en   = rf_we_c;
    assign bus.Out_mem_addr      = addr_q;
    assign bus.Out_mem_wdata     = DATA_W'(bus.In_RF_Read_data);
    assign bus.Out_mem_read_en   = mem_re_c;
    assign bus.Out_mem_write_en  = mem_we_c;
    assign bus.Out_busy          = busy_c;
    assign bus.Out_done          = done_c;
    assign bus.Out_count         = count_q;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Testbench for lm_sm_sequencer: plays memory and register file, predicts
// each beat (register, address) and the final RF/memory contents from the
// mask/base rules, and checks strobes, status and latency cycle by cycle.
module tb_lm_sm_sequencer;

    logic clk;
    logic rst_n;

    lm_sm_sequencer_if bus ();

    lm_sm_sequencer dut (
        .In_clock (clk),
        .In_reset (rst_n),
        .bus      (bus.slave)
    );

    logic [15:0] rf  [8];
    logic [15:0] mem [65536];

    assign bus.In_RF_Read_data = rf[bus.Out_RF_Read_addr];
    assign bus.In_mem_rdata    = mem[bus.Out_mem_addr];

    int vectors = 0;
    int errors  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One complete operation with beat-level checking against the model.
    task automatic run_op(input bit ld, input logic [7:0] m, input logic [15:0] base,
                          input int first_stall, input bit rand_stall, input bit extra_start);
        int          regs_q[$];
        logic [15:0] addrs_q[$];
        logic [15:0] sm_data_q[$];
        logic [15:0] exp_rf [8];
        int          n;
        int          k;
        int          cyc;
        int          stalls;
        int          nstall;
        bit          done_seen;
        bit          rdy;

        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                regs_q.push_back(i);
                addrs_q.push_back(16'(base + 16'(n)));
                n++;
            end
        end
        exp_rf = rf;
        for (int j = 0; j < n; j++) begin
            if (ld) exp_rf[regs_q[j]] = mem[addrs_q[j]];
            else    sm_data_q.push_back(rf[regs_q[j]]);
        end

        @(negedge clk);
        bus.In_start     = 1'b1;
        bus.In_is_load   = ld;
        bus.In_reg_mask  = m;
        bus.In_base_addr = base;
        bus.In_mem_ready = 1'($urandom);
        #1;
        chk("idle_busy", 32'(bus.Out_busy), 0);
        @(posedge clk);

        k = 0; cyc = 0; stalls = first_stall; nstall = 0; done_seen = 1'b0;
        while (!done_seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            // Inputs after the start cycle must have no effect.
            bus.In_start     = extra_start && (cyc == 2);
            bus.In_reg_mask  = ~m;
            bus.In_is_load   = ~ld;
            bus.In_base_addr = 16'($urandom);
            if (k < n) begin
                if (stalls > 0) begin
                    rdy = 1'b0;
                    stalls--;
                end else if (rand_stall) begin
                    rdy = ($urandom_range(0, 3) != 0);
                end else begin
                    rdy = 1'b1;
                end
                if (!rdy) nstall++;
                bus.In_mem_ready = rdy;
                #1;
                chk("acc_busy",   32'(bus.Out_busy), 1);
                chk("acc_done",   32'(bus.Out_done), 0);
                chk("acc_rd_en",  32'(bus.Out_mem_read_en), 32'(ld));
                chk("acc_wr_en",  32'(bus.Out_mem_write_en), 32'(!ld));
                chk("acc_rf_we",  32'(bus.Out_RF_Write_en), 32'(ld && rdy));
                chk("acc_rf_ra",  32'(bus.Out_RF_Read_addr), 32'(regs_q[k]));
                chk("acc_rf_wa",  32'(bus.Out_RF_Write_addr), 32'(regs_q[k]));
                chk("acc_addr",   32'(bus.Out_mem_addr), 32'(addrs_q[k]));
                chk("acc_count",  32'(bus.Out_count), 32'(k));
                if (rdy) begin
                    if (bus.Out_RF_Write_en)  rf[bus.Out_RF_Write_addr] = bus.Out_RF_Write_data;
                    if (bus.Out_mem_write_en) mem[bus.Out_mem_addr] = bus.Out_mem_wdata;
                    k++;
                end
            end else begin
                bus.In_mem_ready = 1'($urandom);
                #1;
                done_seen = bus.Out_done;
                chk("done_pulse", 32'(bus.Out_done), 1);
                chk("done_busy",  32'(bus.Out_busy), 1);
                chk("done_strb",  32'({bus.Out_mem_read_en, bus.Out_mem_write_en, bus.Out_RF_Write_en}), 0);
                chk("done_count", 32'(bus.Out_count), 32'(n));
                chk("latency",    32'(cyc), 32'(n + 1 + nstall));
                done_seen = 1'b1;
            end
        end
        chk("done_reached", 32'(done_seen), 1);

        @(negedge clk);
        bus.In_start = 1'b0;
        #1;
        chk("post_busy",  32'(bus.Out_busy), 0);
        chk("post_done",  32'(bus.Out_done), 0);
        chk("post_count", 32'(bus.Out_count), 32'(n));

        if (ld) begin
            for (int r = 0; r < 8; r++) chk($sformatf("lm_rf_R%0d", r), 32'(rf[r]), 32'(exp_rf[r]));
        end else begin
            for (int j = 0; j < n; j++) chk($sformatf("sm_mem_%0h", addrs_q[j]), 32'(mem[addrs_q[j]]), 32'(sm_data_q[j]));
            for (int r = 0; r < 8; r++) chk($sformatf("sm_rf_R%0d", r), 32'(rf[r]), 32'(exp_rf[r]));
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
        for (int r = 0; r < 8; r++) rf[r] = 16'($urandom);
        rst_n            = 1'b0;
        bus.In_start     = 1'b0;
        bus.In_is_load   = 1'b0;
        bus.In_reg_mask  = '0;
        bus.In_base_addr = '0;
        bus.In_mem_ready = 1'b0;
        #1;
        chk("rst_busy",  32'(bus.Out_busy), 0);
        chk("rst_done",  32'(bus.Out_done), 0);
        chk("rst_count", 32'(bus.Out_count), 0);
        chk("rst_addr",  32'(bus.Out_mem_addr), 0);
        chk("rst_strb",  32'({bus.Out_mem_read_en, bus.Out_mem_write_en, bus.Out_RF_Write_en}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(1'b1, 8'b1010_0101, 16'h0040, 0, 1'b0, 1'b0);
        run_op(1'b0, 8'hFF,        16'hFFFE, 0, 1'b0, 1'b0);
        run_op(1'b1, 8'h00,        16'h1200, 0, 1'b0, 1'b0);
        run_op(1'b0, 8'h00,        16'h3400, 0, 1'b0, 1'b0);
        run_op(1'b1, 8'b0000_0011, 16'h0100, 2, 1'b0, 1'b0);
        run_op(1'b1, 8'b0110_1000, 16'h0200, 0, 1'b0, 1'b1);
        run_op(1'b0, 8'b0001_0110, 16'h0300, 0, 1'b1, 1'b1);

        // Asynchronous reset in the middle of an 8-register SM.
        @(negedge clk);
        bus.In_start     = 1'b1;
        bus.In_is_load   = 1'b0;
        bus.In_reg_mask  = 8'hFF;
        bus.In_base_addr = 16'h5000;
        bus.In_mem_ready = 1'b1;
        @(negedge clk);
        bus.In_start = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        chk("mid_busy", 32'(bus.Out_busy), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy",  32'(bus.Out_busy), 0);
        chk("arst_done",  32'(bus.Out_done), 0);
        chk("arst_count", 32'(bus.Out_count), 0);
        chk("arst_addr",  32'(bus.Out_mem_addr), 0);
        chk("arst_ra",    32'(bus.Out_RF_Read_addr), 0);
        chk("arst_strb",  32'({bus.Out_mem_read_en, bus.Out_mem_write_en, bus.Out_RF_Write_en}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rel_busy",  32'(bus.Out_busy), 0);
        chk("rel_count", 32'(bus.Out_count), 0);
        run_op(1'b0, 8'hFF, 16'h6000, 0, 1'b0, 1'b0);

        for (int t = 0; t < 12; t++) begin
            run_op(1'($urandom), 8'($urandom), 16'($urandom),
                   int'($urandom_range(0, 2)), 1'b1, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
